// File: rtl/usr_cmd_shifter.sv
// Command-driven universal shift register: hold, shift right/left by a repeat count, or parallel load.
// Each command ends with a one-cycle DONE state before the block returns to IDLE.
module usr_cmd_shifter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CNT_W-1:0] shift_cnt,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] data_out,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             r_state;
  state_t             w_stateNext;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   w_dataNext;
  logic [CNT_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   w_remainingNext;
  logic               r_dirRight;
  logic               w_dirRightNext;
  logic               w_accept;
  logic [WIDTH-1:0]   w_shiftRight;
  logic [WIDTH-1:0]   w_shiftLeft;

  assign w_accept     = cmd_valid && (r_state == IDLE);
  assign w_shiftRight = {sin_r, r_data[WIDTH-1:1]};
  assign w_shiftLeft  = {r_data[WIDTH-2:0], sin_l};

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_data      <= '0;
      r_remaining <= '0;
      r_dirRight  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_data      <= w_dataNext;
      r_remaining <= w_remainingNext;
      r_dirRight  <= w_dirRightNext;
    end
  end

  // The first shift of a command happens on the accept edge, so SHIFT only covers the remaining ones.
  always_comb begin
    w_stateNext     = r_state;
    w_dataNext      = r_data;
    w_remainingNext = r_remaining;
    w_dirRightNext  = r_dirRight;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          case (mode)
            MODE_LOAD: begin
              w_dataNext  = data_in;
              w_stateNext = DONE;
            end
            MODE_RIGHT, MODE_LEFT: begin
              w_dirRightNext = (mode == MODE_RIGHT);
              if (shift_cnt == CNT_ZERO) begin
                w_stateNext = DONE;
              end else begin
                w_dataNext = (mode == MODE_RIGHT) ? w_shiftRight : w_shiftLeft;
                if (shift_cnt == CNT_ONE) begin
                  w_stateNext = DONE;
                end else begin
                  w_remainingNext = shift_cnt - CNT_ONE;
                  w_stateNext     = SHIFT;
                end
              end
            end
            MODE_HOLD: begin
              w_stateNext = DONE;
            end
            default: begin
              w_stateNext = DONE;
            end
          endcase
        end
      end
      SHIFT: begin
        w_dataNext      = r_dirRight ? w_shiftRight : w_shiftLeft;
        w_remainingNext = r_remaining - CNT_ONE;
        if (r_remaining == CNT_ONE) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign cmd_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign data_out  = r_data;
  assign sout_r    = r_data[0];
  assign sout_l    = r_data[WIDTH-1];

endmodule

// File: tb/tb_usr_cmd_shifter.sv
// Directed bench for usr_cmd_shifter (WIDTH=4, CNT_W=3) with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_usr_cmd_shifter;

  logic       clock;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] mode;
  logic [3:0] data_in;
  logic [2:0] shift_cnt;
  logic       sin_r;
  logic       sin_l;
  logic [3:0] data_out;
  logic       sout_r;
  logic       sout_l;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  usr_cmd_shifter #(.WIDTH(4), .CNT_W(3)) dut (
    .clock     (clock),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .mode      (mode),
    .data_in   (data_in),
    .shift_cnt (shift_cnt),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
    .data_out  (data_out),
    .sout_r    (sout_r),
    .sout_l    (sout_l),
    .busy      (busy),
    .done      (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic v, input logic [1:0] m, input logic [3:0] d,
                               input logic [2:0] c, input logic sr, input logic sl);
    cmd_valid = v;
    mode      = m;
    data_in   = d;
    shift_cnt = c;
    sin_r     = sr;
    sin_l     = sl;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [3:0] d, input logic rdy,
                            input logic bsy, input logic dn);
    checkOutput({tag, ".data"},  32'(data_out),  32'(d));
    checkOutput({tag, ".ready"}, 32'(cmd_ready), 32'(rdy));
    checkOutput({tag, ".busy"},  32'(busy),      32'(bsy));
    checkOutput({tag, ".done"},  32'(done),      32'(dn));
  endtask

  initial begin
    // Reset with a load command pending: it must not take effect.
    rst = 1'b0;
    applyStimulus(1'b1, 2'b11, 4'b1111, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkState("rst_pending", 4'b0000, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    checkState("rst_release", 4'b0000, 1'b1, 1'b0, 1'b0);

    // Parallel load of 1011.
    applyStimulus(1'b1, 2'b11, 4'b1011, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("load_accept", 4'b1011, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("load_idle", 4'b1011, 1'b1, 1'b0, 1'b0);

    // Shift right x3 with sin_r=1; a load issued while busy must be ignored.
    checkOutput("sr_sout0", 32'(sout_r), 32'd1);
    applyStimulus(1'b1, 2'b01, 4'b0000, 3'd3, 1'b1, 1'b0);
    tick();
    checkState("sr_edge1", 4'b1101, 1'b0, 1'b1, 1'b0);
    checkOutput("sr_sout1", 32'(sout_r), 32'd1);
    applyStimulus(1'b1, 2'b11, 4'b0000, 3'd7, 1'b1, 1'b0);
    tick();
    checkState("sr_edge2", 4'b1110, 1'b0, 1'b1, 1'b0);
    checkOutput("sr_sout2", 32'(sout_r), 32'd0);
    tick();
    checkState("sr_edge3", 4'b1111, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b1, 1'b0);
    tick();
    checkState("sr_idle", 4'b1111, 1'b1, 1'b0, 1'b0);

    // Reload 1011, then shift left x2 with sin_l 0 then 1; mode/count change mid-command.
    applyStimulus(1'b1, 2'b11, 4'b1011, 3'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("reload1", 4'b1011, 1'b1, 1'b0, 1'b0);
    checkOutput("sl_sout0", 32'(sout_l), 32'd1);
    applyStimulus(1'b1, 2'b10, 4'b0000, 3'd2, 1'b0, 1'b0);
    tick();
    checkState("sl_edge1", 4'b0110, 1'b0, 1'b1, 1'b0);
    checkOutput("sl_sout1", 32'(sout_l), 32'd0);
    applyStimulus(1'b1, 2'b01, 4'b0000, 3'd7, 1'b0, 1'b1);
    tick();
    checkState("sl_edge2", 4'b1101, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("sl_idle", 4'b1101, 1'b1, 1'b0, 1'b0);

    // Hold and zero-count shift leave the register untouched but still pulse done.
    applyStimulus(1'b1, 2'b11, 4'b1011, 3'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 2'b00, 4'b0000, 3'd5, 1'b1, 1'b1);
    tick();
    checkState("reload2", 4'b1011, 1'b1, 1'b0, 1'b0);
    tick();
    checkState("hold_done", 4'b1011, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 2'b01, 4'b0000, 3'd0, 1'b1, 1'b1);
    tick();
    checkState("hold_idle", 4'b1011, 1'b1, 1'b0, 1'b0);
    tick();
    checkState("zcnt_done", 4'b1011, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("zcnt_idle", 4'b1011, 1'b1, 1'b0, 1'b0);

    // Shift right x7 with sin_r=0, aborted by an asynchronous reset after three shifts.
    applyStimulus(1'b1, 2'b01, 4'b0000, 3'd7, 1'b0, 1'b0);
    tick();
    checkState("abort_e1", 4'b0101, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    tick();
    checkState("abort_e3", 4'b0001, 1'b0, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checkState("abort_rst", 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    checkState("abort_hold", 4'b0000, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 2'b11, 4'b0101, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("post_load", 4'b0101, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 2'b00, 4'b0000, 3'd0, 1'b0, 1'b0);
    tick();
    checkState("post_idle", 4'b0101, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
